pc_gen: RTL and testbench

//  Parametrised fetch-PC generator, successor to the single-cycle PC register.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_redirect_mux.sv | 53 +++++
 rtl/pc_gen.sv | 125 ++++++++++++
 tb/tb_pc_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-PC generator.
// Optional trap redirect is enabled by defining PC_TRAP_EN.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        ERR  = 2'd3
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_SEQ  = 3'd1,
        SEL_BR   = 3'd2,
        SEL_JALR = 3'd3,
        SEL_TRAP = 3'd4
    } pc_sel_e;

    localparam int PC_INC = 4;

endpackage

// File: rtl/pc_redirect_mux.sv
// Combinational next-pc priority encoder: trap > jalr > branch > stall > fire > hold.
// Flags a misaligned branch/JALR target; the trap vector is trusted to be aligned.
module pc_redirect_mux
    import pc_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter logic [WIDTH-1:0] TRAP_VECTOR = 'h100
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic             trap_req,
    input  logic             jalr_en,
    input  logic [WIDTH-1:0] jalr_base,
    input  logic [WIDTH-1:0] jalr_imm,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_imm,
    input  logic             stall,
    input  logic             fire,
    output pc_sel_e          sel,
    output logic [WIDTH-1:0] next_pc,
    output logic             misalign
);

    logic [WIDTH-1:0] jalr_target;
    logic [WIDTH-1:0] br_target;

    always_comb begin
        jalr_target = (jalr_base + jalr_imm) & ~WIDTH'(1);
        br_target   = pc + branch_imm;
        sel         = SEL_HOLD;
        next_pc     = pc;
        misalign    = 1'b0;
        if (trap_req) begin
            sel     = SEL_TRAP;
            next_pc = TRAP_VECTOR;
        end else if (jalr_en) begin
            sel      = SEL_JALR;
            next_pc  = jalr_target;
            misalign = |jalr_target[1:0];
        end else if (branch_taken) begin
            sel      = SEL_BR;
            next_pc  = br_target;
            misalign = |br_target[1:0];
        end else if (stall) begin
            sel     = SEL_HOLD;
            next_pc = pc;
        end else if (fire) begin
            sel     = SEL_SEQ;
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: BOOT/RUN/HALT/ERR FSM, pc register and misalign pulse.
// Define PC_TRAP_EN to add trap_req/epc and redirect faults to TRAP_VECTOR.
module pc_gen
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 'h0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = 'h100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_imm,
    input  logic             jalr_en,
    input  logic [WIDTH-1:0] jalr_base,
    input  logic [WIDTH-1:0] jalr_imm,
    input  logic             stall,
    input  logic             halt,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             misalign,
`ifdef PC_TRAP_EN
    input  logic             trap_req,
    output logic [WIDTH-1:0] epc,
`endif
    output pc_state_e        state
);

    // Handshake: a fetch of pc completes on an edge where fetch_valid && fetch_ready;
    // fetch_valid is high only in RUN and pc stays stable until the fetch completes or a redirect wins.

    pc_state_e        state_next;
    pc_sel_e          sel;
    logic [WIDTH-1:0] next_pc;
    logic             mis_cand;
    logic             fire;
    logic             trap_in;

`ifdef PC_TRAP_EN
    assign trap_in = trap_req;
`else
    assign trap_in = 1'b0;
`endif

    assign fetch_valid = (state == RUN);
    assign fire        = fetch_valid & fetch_ready;
    assign pc_plus4    = pc + WIDTH'(PC_INC);

    pc_redirect_mux #(
        .WIDTH       (WIDTH),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_mux (
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .trap_req     (trap_in),
        .jalr_en      (jalr_en),
        .jalr_base    (jalr_base),
        .jalr_imm     (jalr_imm),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .stall        (stall),
        .fire         (fire),
        .sel          (sel),
        .next_pc      (next_pc),
        .misalign     (mis_cand)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
`ifdef PC_TRAP_EN
                if (halt) state_next = HALT;
`else
                if (mis_cand)  state_next = ERR;
                else if (halt) state_next = HALT;
`endif
            end
            HALT: if (!halt) state_next = RUN;
            ERR:  state_next = ERR;
            default: state_next = BOOT;
        endcase
    end

    // pc only moves in RUN; a misaligned target is never loaded into pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_VECTOR;
            misalign <= 1'b0;
        end else if (state == RUN) begin
            misalign <= mis_cand;
            if (mis_cand) begin
`ifdef PC_TRAP_EN
                pc <= TRAP_VECTOR;
`endif
            end else if (sel != SEL_HOLD) begin
                pc <= next_pc;
            end
        end else begin
            misalign <= 1'b0;
        end
    end

`ifdef PC_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc <= '0;
        end else if (state == RUN && (mis_cand || sel == SEL_TRAP)) begin
            epc <= pc;
        end
    end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen; builds with or without PC_TRAP_EN.
module tb_pc_gen;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_taken;
    logic [31:0] branch_imm;
    logic        jalr_en;
    logic [31:0] jalr_base;
    logic [31:0] jalr_imm;
    logic        stall;
    logic        halt;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;
    pc_state_e   state;
`ifdef PC_TRAP_EN
    logic        trap_req;
    logic [31:0] epc;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0),
        .TRAP_VECTOR  (32'h100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jalr_en      (jalr_en),
        .jalr_base    (jalr_base),
        .jalr_imm     (jalr_imm),
        .stall        (stall),
        .halt         (halt),
        .fetch_ready  (fetch_ready),
        .fetch_valid  (fetch_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .misalign     (misalign),
`ifdef PC_TRAP_EN
        .trap_req     (trap_req),
        .epc          (epc),
`endif
        .state        (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        branch_taken = 1'b0;
        branch_imm   = '0;
        jalr_en      = 1'b0;
        jalr_base    = '0;
        jalr_imm     = '0;
        stall        = 1'b0;
        halt         = 1'b0;
`ifdef PC_TRAP_EN
        trap_req     = 1'b0;
`endif
    endtask

    initial begin
        rst_n       = 1'b0;
        fetch_ready = 1'b1;
        idle_inputs();
        #23;
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'b0, fetch_valid}, 32'h0);
        check("rst_misalign", {31'b0, misalign}, 32'h0);
        check("rst_state", {30'b0, state}, {30'b0, BOOT});
`ifdef PC_TRAP_EN
        check("rst_epc", epc, 32'h0);
`endif
        rst_n = 1'b1;

        // Boot then sequential fetch
        step();
        check("boot_state", {30'b0, state}, {30'b0, RUN});
        check("boot_pc", pc, 32'h0);
        check("boot_valid", {31'b0, fetch_valid}, 32'h1);
        step();
        check("seq_pc4", pc, 32'h4);
        step();
        check("seq_pc8", pc, 32'h8);
        check("seq_plus4", pc_plus4, 32'hC);

        // Back-pressure holds pc
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_pc", pc, 32'h8);
            check("bp_valid", {31'b0, fetch_valid}, 32'h1);
        end
        fetch_ready = 1'b1;
        step();
        check("bp_release", pc, 32'hC);
        step();
        check("seq_pc16", pc, 32'h10);

        // Branch beats stall
        branch_taken = 1'b1;
        branch_imm   = -32'sd8;
        stall        = 1'b1;
        step();
        check("br_over_stall", pc, 32'h8);
        idle_inputs();

        // JALR beats branch, bit 0 cleared
        jalr_en      = 1'b1;
        jalr_base    = 32'h41;
        jalr_imm     = 32'h3;
        branch_taken = 1'b1;
        branch_imm   = 32'h20;
        step();
        check("jalr_pc", pc, 32'h44);
        check("jalr_misalign", {31'b0, misalign}, 32'h0);
        idle_inputs();

        stall = 1'b1;
        step();
        check("stall_hold", pc, 32'h44);
        idle_inputs();

        // Move to pc=20 then halt with a refused fetch on the entry edge
        jalr_en   = 1'b1;
        jalr_base = 32'd20;
        step();
        check("jalr_20", pc, 32'd20);
        idle_inputs();
        halt        = 1'b1;
        fetch_ready = 1'b0;
        step();
        check("halt_state", {30'b0, state}, {30'b0, HALT});
        fetch_ready  = 1'b1;
        branch_taken = 1'b1;
        branch_imm   = 32'h8;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_pc", pc, 32'd20);
            check("halt_valid", {31'b0, fetch_valid}, 32'h0);
        end
        idle_inputs();
        step();
        check("unhalt_state", {30'b0, state}, {30'b0, RUN});
        check("unhalt_pc", pc, 32'd20);
        step();
        check("unhalt_fire", pc, 32'd24);

        // halt together with redirect: redirect taken, then HALT
        halt         = 1'b1;
        branch_taken = 1'b1;
        branch_imm   = 32'd16;
        step();
        check("halt_br_pc", pc, 32'd40);
        check("halt_br_state", {30'b0, state}, {30'b0, HALT});
        idle_inputs();
        step();
        check("halt_br_run", {30'b0, state}, {30'b0, RUN});

        // Wrap-around at the top of the address space
        jalr_en   = 1'b1;
        jalr_base = 32'hFFFF_FFFC;
        step();
        check("wrap_pre", pc, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0);
        idle_inputs();
        step();
        check("wrap_pc", pc, 32'h0);
        step();
        check("pre_rst_pc", pc, 32'h4);

        // Asynchronous reset while stalled
        stall = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pc", pc, 32'h0);
        check("async_valid", {31'b0, fetch_valid}, 32'h0);
        check("async_state", {30'b0, state}, {30'b0, BOOT});
        idle_inputs();
        #5;
        rst_n = 1'b1;
        step();
        check("rerun_state", {30'b0, state}, {30'b0, RUN});
        check("rerun_pc", pc, 32'h0);

        // Misaligned branch target at pc=0
        branch_taken = 1'b1;
        branch_imm   = 32'd6;
        step();
        check("mis_pulse", {31'b0, misalign}, 32'h1);
`ifdef PC_TRAP_EN
        check("mis_pc_trap", pc, 32'h100);
        check("mis_epc", epc, 32'h0);
        check("mis_valid_trap", {31'b0, fetch_valid}, 32'h1);
        idle_inputs();
        step();
        check("mis_pulse_end", {31'b0, misalign}, 32'h0);
        check("trap_seq", pc, 32'h104);
        trap_req = 1'b1;
        stall    = 1'b1;
        step();
        check("trap_pc", pc, 32'h100);
        check("trap_epc", epc, 32'h104);
        idle_inputs();
`else
        check("mis_pc", pc, 32'h0);
        check("mis_state", {30'b0, state}, {30'b0, ERR});
        check("mis_valid", {31'b0, fetch_valid}, 32'h0);
        idle_inputs();
        branch_taken = 1'b1;
        branch_imm   = 32'd8;
        for (int i = 0; i < 3; i++) begin
            step();
            check("err_misalign", {31'b0, misalign}, 32'h0);
            check("err_pc", pc, 32'h0);
            check("err_valid", {31'b0, fetch_valid}, 32'h0);
        end
        idle_inputs();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
